// File: rtl/mpi_pkg.sv
// Shared MPI types and constants: Wishbone bridge FSM encoding, cycle-type codes, timeout width.
package mpi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mpi_wb_state_t;

    // Cycle-type codes kept for the future burst-capable bridge.
    localparam logic [2:0] MPI_WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] MPI_WB_CTI_EOB     = 3'b111;

    localparam int MPI_WB_TO_W = 16;

endpackage

// File: rtl/mpi_wb_bridge_if.sv
// Wishbone B3 single-beat bus between a tile master and the MPI buffer bridge.
interface mpi_wb_bridge_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/mpi_wb_bridge.sv
// Wishbone B3 slave front end for the MPI message buffer: single-beat cycles become a held
// bus_en request with local legality check, timeout and registered read data.
module mpi_wb_bridge
    import mpi_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mpi_wb_bridge_if.slave       wb,
    output logic [31:0]          bus_addr,
    output logic                 bus_we,
    output logic                 bus_en,
    output logic [31:0]          bus_data_in,
    input  logic [31:0]          bus_data_out,
    input  logic                 bus_ack,
    input  logic                 bus_err
);

    localparam logic [MPI_WB_TO_W-1:0] TO_LAST = MPI_WB_TO_W'(TIMEOUT - 1);

    mpi_wb_state_t           state_q;
    logic [MPI_WB_TO_W-1:0]  cnt_q;
    logic [MPI_WB_TO_W-1:0]  cnt_d;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    we_q;
    logic                    en_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    illegal_d;
    logic                    unused_ok;

    // Every beat is classic, so cycle/burst type are deliberately ignored.
    assign unused_ok = ^{wb.wb_cti_i, wb.wb_bte_i};

    assign illegal_d = (wb.wb_adr_i[1:0] != 2'b00) || (wb.wb_we_i && (wb.wb_sel_i != 4'hF));
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // NOTE: one clocked process owns all state and outputs; non-blocking assignments keep every
    // register reading the pre-edge value, and the async reset covers data registers as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wb.wb_cyc_i && wb.wb_stb_i) begin
                        addr_q  <= wb.wb_adr_i;
                        we_q    <= wb.wb_we_i;
                        wdata_q <= wb.wb_dat_i;
                        cnt_q   <= '0;
                        if (illegal_d) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            en_q    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    // Abort beats any buffer response; the buffer access is simply dropped.
                    if (!wb.wb_cyc_i) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                    end else if (bus_err || bus_ack || (cnt_q == TO_LAST)) begin
                        state_q <= RESP;
                        en_q    <= 1'b0;
                        if (bus_ack && !bus_err) begin
                            ack_q <= 1'b1;
                            if (!we_q) rdata_q <= bus_data_out;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_addr     = addr_q;
    assign bus_we       = we_q;
    assign bus_en       = en_q;
    assign bus_data_in  = wdata_q;
    assign wb.wb_dat_o  = rdata_q;
    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_err_o  = err_q;
    assign wb.wb_rty_o  = 1'b0;

endmodule

// File: tb/tb_mpi_wb_bridge.sv
// Scoreboard bench for mpi_wb_bridge: a driver plays master and buffer, a monitor checks responses.
module tb_mpi_wb_bridge;
    import mpi_pkg::*;

    localparam int TO = 4;
    localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr, bus_data_in;
    logic [31:0] bus_data_out = '0;
    logic        bus_we, bus_en;
    logic        bus_ack = 1'b0, bus_err = 1'b0;

    mpi_wb_bridge_if wb ();

    mpi_wb_bridge #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_en       (bus_en),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        int          cyc;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       r;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    logic [31:0] model_dat = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (wb.wb_ack_o || wb.wb_err_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {wb.wb_ack_o, wb.wb_err_o}, 2'b00);
            end else begin
                r = exp_q.pop_front();
                check("resp_kind", {wb.wb_ack_o, wb.wb_err_o}, r.is_err ? 2'b01 : 2'b10);
                check("resp_cycle", cyc_cnt, r.cyc);
                check("wb_dat_o", wb.wb_dat_o, r.dat);
            end
        end
    end

    // One Wishbone beat. kind: buffer reply type; delay: buffer stall cycles; abort_at: REQ
    // cycle in which cyc is dropped (0 = never); rd: buffer read data.
    task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int kind, input int delay, input int abort_at,
                       input logic [31:0] rd);
        bit illegal, timed, has_resp, resp_err, stable_ok;
        int rc, end_c, resp_at, exp_en, en_cnt;
        illegal  = (adr[1:0] != 2'b00) || (we && sel != 4'hF);
        rc       = delay + 1;
        has_resp = 1'b0;
        resp_err = 1'b0;
        resp_at  = 0;
        if (illegal) begin
            has_resp = 1'b1; resp_err = 1'b1; resp_at = 1; exp_en = 0;
        end else begin
            timed = (kind == K_SILENT) || (rc > TO);
            end_c = timed ? TO : rc;
            if (abort_at > 0 && abort_at <= end_c) begin
                exp_en = abort_at;
            end else begin
                has_resp = 1'b1;
                exp_en   = end_c;
                resp_at  = end_c + 1;
                resp_err = timed || (kind != K_ACK);
                if (!resp_err && !we) model_dat = rd;
            end
        end

        @(negedge clk);
        if (has_resp) exp_q.push_back('{resp_err, model_dat, cyc_cnt + resp_at});
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_we_i  = we;
        wb.wb_cti_i = 3'($urandom);
        wb.wb_bte_i = 2'($urandom);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        en_cnt      = 0;
        stable_ok   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (bus_en) begin
                en_cnt++;
                if (bus_addr !== adr || bus_we !== we || bus_data_in !== dat) stable_ok = 1'b0;
            end
            if (wb.wb_ack_o || wb.wb_err_o) break;
            if (abort_at > 0 && c >= abort_at) begin
                wb.wb_cyc_i = 1'b0;
                wb.wb_stb_i = 1'b0;
                if (c >= abort_at + 2) break;
            end
            if (!illegal && c == rc && kind != K_SILENT) begin
                bus_ack      = (kind == K_ACK) || (kind == K_BOTH);
                bus_err      = (kind == K_ERR) || (kind == K_BOTH);
                bus_data_out = rd;
            end else begin
                bus_data_out = $urandom;
            end
        end
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        bus_ack     = 1'b0;
        bus_err     = 1'b0;
        check("bus_en_cycles", en_cnt, exp_en);
        check("bus_fields_stable", stable_ok, 1'b1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        wb.wb_adr_i = 32'h0000_0040;
        wb.wb_dat_i = 32'h1234_5678;
        wb.wb_sel_i = 4'hF;
        wb.wb_we_i  = 1'b1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        @(negedge clk);
        check("pre_reset_bus_en", {bus_en, bus_we}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ctrl", {bus_en, bus_we, wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o}, 5'b0);
        check("rst_mid_addr", bus_addr, 32'h0);
        check("rst_mid_wdata", bus_data_in, 32'h0);
        check("rst_mid_rdata", wb.wb_dat_o, 32'h0);
        model_dat   = '0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          ab;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_we_i = 1'b0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cti_i = '0; wb.wb_bte_i = '0;
        #1;
        check("reset_ctrl", {bus_en, bus_we, wb.wb_ack_o, wb.wb_err_o, wb.wb_rty_o}, 5'b0);
        check("reset_data", {bus_addr, bus_data_in}, 64'h0);
        check("reset_rdata", wb.wb_dat_o, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        txn(32'h0000_0000, 32'h0,         4'hF, 1'b0, K_ACK,    0, 0, 32'h0000_0001);
        txn(32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 1'b1, K_ACK,    3, 0, 32'hCAFE_F00D);
        txn(32'h0000_0010, 32'h0,         4'h1, 1'b0, K_ERR,    1, 0, 32'h5555_AAAA);
        txn(32'h0000_0014, 32'h0,         4'hF, 1'b0, K_BOTH,   0, 0, 32'h7777_7777);
        txn(32'h0000_0018, 32'h0,         4'hF, 1'b0, K_SILENT, 0, 0, 32'h0BAD_0BAD);
        txn(32'h0000_001C, 32'h0,         4'hF, 1'b0, K_ACK,    3, 0, 32'hA5A5_0003);
        txn(32'h0000_0020, 32'h0,         4'hF, 1'b0, K_ACK,    4, 0, 32'hA5A5_0004);
        txn(32'h0000_3000, 32'h1111_2222, 4'h3, 1'b1, K_ACK,    0, 0, 32'h0);
        txn(32'h0000_2002, 32'h0,         4'hF, 1'b0, K_ACK,    0, 0, 32'h3333_4444);
        txn(32'h0000_0024, 32'h0,         4'hF, 1'b0, K_ACK,    2, 2, 32'h9999_9999);
        txn(32'h0000_0028, 32'h0,         4'hF, 1'b0, K_ACK,    0, 1, 32'h8888_8888);
        reset_mid();
        txn(32'h0000_0100, 32'h0,         4'hF, 1'b0, K_ACK,    1, 0, 32'h0FED_CBA9);

        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
            txn(a, $urandom, s, 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), ab, $urandom);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
